// File: rtl/tagged_mem_port_if.sv
// tagged_mem_port_if: CPU-side bus of the tagged memory port.
// The CPU drives the i_* requests and the memory returns the o_* data and one-cycle flags.
interface tagged_mem_port_if;
    logic [63:0] i_ad;
    logic [7:0]  i_tag;
    logic        i_astb;
    logic        i_atomic;
    logic        i_rd;
    logic        i_wr;
    logic        i_wforce;
    logic [63:0] o_data;
    logic [7:0]  o_tag;
    logic        o_nomem;
    logic        o_wprot;
    logic        o_rmwerr;

    modport master (
        output i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, i_wforce,
        input  o_data, o_tag, o_nomem, o_wprot, o_rmwerr
    );

    modport slave (
        input  i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, i_wforce,
        output o_data, o_tag, o_nomem, o_wprot, o_rmwerr
    );
endinterface

// File: rtl/tagged_mem_port.sv
// tagged_mem_port: tagged 64-bit memory with write protection, absent-address detection
// and an atomic read-modify-write sequence tracked by a small FSM.
module tagged_mem_port #(
    parameter int ADDR_W = 10,
    parameter int LIMIT  = 2**ADDR_W
) (
    input logic              clk,
    input logic              reset,
    tagged_mem_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, RMW_RD, RMW_WR} state_t;

    state_t              state, state_nx;
    logic [63:0]         mem_data [2**ADDR_W];
    logic [7:0]          mem_tag  [2**ADDR_W];
    logic [19:0]         addr, eff;
    logic                atomic;
    logic [ADDR_W-1:0]   idx;
    logic                absent, in_rmw, rmw_drop, bypass, blocked, we, re;

    always_comb begin
        eff      = bus.i_astb ? bus.i_ad[19:0] : addr;
        idx      = eff[ADDR_W-1:0];
        absent   = (32'(eff) >= 32'(LIMIT)) || ((eff >> ADDR_W) != '0);
        in_rmw   = (state == RMW_RD) || (state == RMW_WR);
        rmw_drop = bus.i_wr && !bus.i_astb && (state == RMW_RD);
        // The read half of an atomic sequence already validated the word.
        bypass   = (state == RMW_WR) && atomic && !bus.i_astb;
        blocked  = bus.i_wr && !rmw_drop && !absent && mem_tag[idx][7] && !bus.i_wforce && !bypass;
        we       = bus.i_wr && !rmw_drop && !absent && !blocked;
        re       = bus.i_rd && !bus.i_wr;
        state_nx = bus.i_astb                     ? (bus.i_atomic ? RMW_RD : ADDR) :
                   (state == RMW_RD && rmw_drop)  ? ADDR :
                   (state == RMW_RD && re)        ? RMW_WR :
                   (state == RMW_WR && bus.i_wr)  ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            atomic       <= 1'b0;
            bus.o_data   <= '0;
            bus.o_tag    <= '0;
            bus.o_nomem  <= 1'b0;
            bus.o_wprot  <= 1'b0;
            bus.o_rmwerr <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.i_astb) begin
                addr   <= bus.i_ad[19:0];
                atomic <= bus.i_atomic;
            end
            if (re) begin
                bus.o_data <= absent ? '0 : mem_data[idx];
                bus.o_tag  <= absent ? '0 : mem_tag[idx];
            end
            bus.o_nomem  <= (bus.i_rd || bus.i_wr) && absent;
            bus.o_wprot  <= blocked;
            bus.o_rmwerr <= (bus.i_astb && in_rmw) || rmw_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem_data[idx] <= bus.i_ad;
            mem_tag[idx]  <= bus.i_tag;
        end
    end
endmodule

// File: tb/tb_tagged_mem_port.sv
// tb_tagged_mem_port: directed vectors with hand-computed expectations for tagged_mem_port.
// LIMIT is lowered to 1000 so the absent-address boundary sits inside the array.
module tb_tagged_mem_port;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errs = 0;

    tagged_mem_port_if bus ();

    tagged_mem_port #(.ADDR_W(10), .LIMIT(1000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic op(input logic astb, input logic atm, input logic rd, input logic wr,
                      input logic frc, input logic [63:0] ad, input logic [7:0] tg);
        bus.i_astb   = astb;
        bus.i_atomic = atm;
        bus.i_rd     = rd;
        bus.i_wr     = wr;
        bus.i_wforce = frc;
        bus.i_ad     = ad;
        bus.i_tag    = tg;
        @(posedge clk);
        #1;
        bus.i_astb   = 1'b0;
        bus.i_atomic = 1'b0;
        bus.i_rd     = 1'b0;
        bus.i_wr     = 1'b0;
        bus.i_wforce = 1'b0;
        bus.i_ad     = '0;
        bus.i_tag    = '0;
    endtask

    task automatic strobe(input logic [19:0] a, input logic atm);
        op(1'b1, atm, 1'b0, 1'b0, 1'b0, 64'(a), 8'h00);
    endtask

    task automatic wr(input logic [63:0] d, input logic [7:0] t, input logic frc);
        op(1'b0, 1'b0, 1'b0, 1'b1, frc, d, t);
    endtask

    task automatic rd();
        op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic flags(input string name, input logic [2:0] exp);
        check(name, 64'({bus.o_nomem, bus.o_wprot, bus.o_rmwerr}), 64'(exp));
    endtask

    initial begin
        reset = 1'b1;
        idle();
        idle();
        check("rst_data", bus.o_data, 64'h0);
        check("rst_tag", 64'(bus.o_tag), 64'h0);
        flags("rst_flags", 3'b000);
        check("rst_state", 64'(dut.state), 64'd0);
        reset = 1'b0;
        idle();

        // known contents for the words touched below
        strobe(20'h123, 1'b0); wr(64'h1111, 8'h01, 1'b1);
        strobe(20'h005, 1'b0); wr(64'hDEADBEEF_00000001, 8'h35, 1'b1);
        flags("wr5_flags", 3'b000);
        rd();
        check("rd5_data", bus.o_data, 64'hDEADBEEF_00000001);
        check("rd5_tag", 64'(bus.o_tag), 64'h35);

        // upper address bits set: absent, write discarded, read returns zero
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h01123, 8'h77);
        flags("nomem_wr", 3'b100);
        rd();
        check("nomem_rd_data", bus.o_data, 64'h0);
        check("nomem_rd_tag", 64'(bus.o_tag), 64'h0);
        flags("nomem_rd_flag", 3'b100);
        idle();
        flags("nomem_clear", 3'b000);
        strobe(20'h123, 1'b0); rd();
        check("alias_123", bus.o_data, 64'h1111);

        // LIMIT boundary
        strobe(20'd999, 1'b0); wr(64'h999, 8'h02, 1'b1); rd();
        check("lim_999", bus.o_data, 64'h999);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd1000, 8'h00);
        check("lim_1000_data", bus.o_data, 64'h0);
        flags("lim_1000_flag", 3'b100);

        // write protection
        strobe(20'h006, 1'b0); wr(64'hAAAA, 8'h80, 1'b1);
        wr(64'h1234, 8'h00, 1'b0);
        flags("wprot_set", 3'b010);
        idle();
        flags("wprot_clear", 3'b000);
        rd();
        check("wprot_kept", bus.o_data, 64'hAAAA);
        check("wprot_kept_tag", 64'(bus.o_tag), 64'h80);
        wr(64'h1234, 8'h80, 1'b1);
        flags("wforce_flags", 3'b000);
        rd();
        check("wforce_data", bus.o_data, 64'h1234);

        // clean atomic sequence bypasses protection
        strobe(20'h006, 1'b1);
        rd();
        check("rmw_rd", bus.o_data, 64'h1234);
        check("rmw_state_wr", 64'(dut.state), 64'd3);
        wr(64'h55, 8'h80, 1'b0);
        flags("rmw_flags", 3'b000);
        check("rmw_idle", 64'(dut.state), 64'd0);
        rd();
        check("rmw_result", bus.o_data, 64'h55);

        // strobe breaks the atomic sequence
        strobe(20'h005, 1'b1); rd();
        strobe(20'h007, 1'b0);
        flags("rmwerr_astb", 3'b001);
        check("rmwerr_state", 64'(dut.state), 64'd1);
        wr(64'h777, 8'h03, 1'b1);
        flags("rmwerr_clear", 3'b000);
        rd();
        check("new_addr_7", bus.o_data, 64'h777);
        strobe(20'h005, 1'b0); rd();
        check("addr5_kept", bus.o_data, 64'hDEADBEEF_00000001);

        // write during RMW_RD is discarded
        strobe(20'h007, 1'b1);
        wr(64'h888, 8'h04, 1'b1);
        flags("rmwrd_wr", 3'b001);
        rd();
        check("rmwrd_discard", bus.o_data, 64'h777);

        // rd and wr together: write wins, outputs hold
        strobe(20'h005, 1'b0);
        op(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'hBBBB, 8'h04);
        check("rdwr_hold", bus.o_data, 64'h777);
        rd();
        check("rdwr_written", bus.o_data, 64'hBBBB);

        // reset in RMW_WR with write pending
        strobe(20'h007, 1'b1); rd();
        check("pre_rst_state", 64'(dut.state), 64'd3);
        reset = 1'b1;
        op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h999, 8'h00);
        check("rst_rmw_data", bus.o_data, 64'h0);
        flags("rst_rmw_flags", 3'b000);
        check("rst_rmw_state", 64'(dut.state), 64'd0);
        reset = 1'b0;
        idle();
        flags("post_rst_flags", 3'b000);
        strobe(20'h007, 1'b0); rd();
        check("rst_no_write", bus.o_data, 64'h777);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
